// File: rtl/replay_pkg.sv
// Shared types and helpers for the replay run controller.
// Holds the run-state encoding, the watchdog exit code and an index-width helper.
package replay_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int CODE_W_DEF = 32;
    localparam logic [CODE_W_DEF-1:0] CODE_TIMEOUT = '1;

    // Width of an index into n items; never zero so single-item ports stay legal.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/replay_exit_arb.sv
// Lowest-index-wins select over the exit request channels.
// Purely combinational (zero latency); requests are levels, so there is no backpressure.
module replay_exit_arb
    import replay_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CODE_W = 32
) (
    input  logic [NUM_CH-1:0]         exit_vld,
    input  logic [NUM_CH*CODE_W-1:0]  exit_code,
    output logic                      any_vld,
    output logic [idx_w(NUM_CH)-1:0]  win_idx,
    output logic [CODE_W-1:0]         win_code
);

    localparam int IDX_W = idx_w(NUM_CH);

    // Scan high to low so the lowest set channel is the last write and wins.
    always_comb begin
        any_vld  = 1'b0;
        win_idx  = '0;
        win_code = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (exit_vld[i]) begin
                any_vld  = 1'b1;
                win_idx  = IDX_W'(i);
                win_code = exit_code[i*CODE_W +: CODE_W];
            end
        end
    end

endmodule

// File: rtl/replay_ctrl.sv
// Run controller: holds DUT reset, counts ticked cycles, captures the first exit or watchdog, drains, then latches a verdict.
// All outputs registered; exit seen at edge N gives done after edge N+DRAIN_CYCLES+1. Exit requests are levels, never stalled.
module replay_ctrl
    import replay_pkg::*;
#(
    parameter int              NUM_CH       = 4,
    parameter int              CODE_W       = 32,
    parameter int              CYC_W        = 65,
    parameter int              RST_CYCLES   = 5,
    parameter int              DRAIN_CYCLES = 2,
    parameter longint unsigned TIMEOUT      = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick_en,
    input  logic [NUM_CH-1:0]         exit_vld,
    input  logic [NUM_CH*CODE_W-1:0]  exit_code,
    output logic                      dut_reset,
    output logic                      running,
    output logic [CYC_W-1:0]          cycles,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [idx_w(NUM_CH)-1:0]  exit_ch,
    output logic [CODE_W-1:0]         exitcode
);

    localparam int IDX_W = idx_w(NUM_CH);
    localparam int RST_W = idx_w(RST_CYCLES);
    localparam int DRN_W = idx_w(DRAIN_CYCLES);

    localparam logic [RST_W-1:0]  RST_LAST   = RST_W'(RST_CYCLES - 1);
    localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(DRAIN_CYCLES - 1);
    localparam logic              WDOG_EN    = (TIMEOUT != 0);
    localparam logic [CYC_W-1:0]  TO_LAST    = CYC_W'(TIMEOUT - 64'd1);
    localparam logic [CODE_W-1:0] TMO_CODE   = {CODE_W{CODE_TIMEOUT[0]}};

    if (NUM_CH < 1) begin : g_chk_num_ch
        $error("replay_ctrl: NUM_CH must be >= 1");
    end
    if (RST_CYCLES < 1) begin : g_chk_rst_cycles
        $error("replay_ctrl: RST_CYCLES must be >= 1");
    end
    if ((TIMEOUT >> CYC_W) != 0) begin : g_chk_timeout
        $error("replay_ctrl: TIMEOUT does not fit in CYC_W bits");
    end

    logic              any_vld;
    logic [IDX_W-1:0]  arb_idx;
    logic [CODE_W-1:0] arb_code;

    replay_exit_arb #(
        .NUM_CH (NUM_CH),
        .CODE_W (CODE_W)
    ) u_arb (
        .exit_vld  (exit_vld),
        .exit_code (exit_code),
        .any_vld   (any_vld),
        .win_idx   (arb_idx),
        .win_code  (arb_code)
    );

    state_e            state_q,     state_d;
    logic [RST_W-1:0]  rst_cnt_q,   rst_cnt_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [CYC_W-1:0]  cycles_q,    cycles_d;
    logic [IDX_W-1:0]  exit_ch_q,   exit_ch_d;
    logic [CODE_W-1:0] exitcode_q,  exitcode_d;
    logic              timeout_q,   timeout_d;
    logic              done_q,      done_d;
    logic              pass_q,      pass_d;
    logic              dut_reset_q, dut_reset_d;
    logic              running_q,   running_d;
    logic              wdog_fire;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_HOLD;
            rst_cnt_q   <= '0;
            drain_cnt_q <= '0;
            cycles_q    <= '0;
            exit_ch_q   <= '0;
            exitcode_q  <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cycles_q    <= cycles_d;
            exit_ch_q   <= exit_ch_d;
            exitcode_q  <= exitcode_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            dut_reset_q <= dut_reset_d;
            running_q   <= running_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        cycles_d    = cycles_q;
        exit_ch_d   = exit_ch_q;
        exitcode_d  = exitcode_q;
        timeout_d   = timeout_q;
        wdog_fire   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            ST_RUN: begin
                if (tick_en && (cycles_q != '1)) begin
                    cycles_d = cycles_q + CYC_W'(1);
                end
                // A real exit in the same cycle outranks the watchdog.
                wdog_fire = WDOG_EN && tick_en && (cycles_q == TO_LAST) && !any_vld;
                if (any_vld || wdog_fire) begin
                    state_d     = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                    drain_cnt_d = '0;
                    exit_ch_d   = wdog_fire ? '0 : arb_idx;
                    exitcode_d  = wdog_fire ? TMO_CODE : arb_code;
                    timeout_d   = wdog_fire;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DRN_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Verdict is registered from the DONE state, one edge after entering it.
    always_comb begin
        dut_reset_d = (state_d == ST_HOLD);
        running_d   = (state_d == ST_RUN);
        done_d      = (state_q == ST_DONE);
        pass_d      = (state_q == ST_DONE) && (exitcode_q == '0) && !timeout_q;
    end

    assign dut_reset = dut_reset_q;
    assign running   = running_q;
    assign cycles    = cycles_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign exit_ch   = exit_ch_q;
    assign exitcode  = exitcode_q;

endmodule

// File: tb/tb_replay_ctrl.sv
// Directed bench for replay_ctrl: four instances (default, watchdog, narrow counter, no drain)
// share one stimulus stream and are checked with immediate assertions after each edge.
module tb_replay_ctrl;

    logic         clock;
    logic         reset;
    logic         tick_en;
    logic [3:0]   exit_vld;
    logic [127:0] exit_code;

    int checks = 0;
    int errors = 0;

    // u0: defaults (TIMEOUT=0, DRAIN_CYCLES=2)
    logic        a_dut_reset, a_running, a_done, a_pass, a_timeout;
    logic [64:0] a_cycles;
    logic [1:0]  a_exit_ch;
    logic [31:0] a_exitcode;
    // u1: TIMEOUT=100
    logic        b_dut_reset, b_running, b_done, b_pass, b_timeout;
    logic [64:0] b_cycles;
    logic [1:0]  b_exit_ch;
    logic [31:0] b_exitcode;
    // u2: CYC_W=4
    logic        c_dut_reset, c_running, c_done, c_pass, c_timeout;
    logic [3:0]  c_cycles;
    logic [1:0]  c_exit_ch;
    logic [31:0] c_exitcode;
    // u3: DRAIN_CYCLES=0
    logic        d_dut_reset, d_running, d_done, d_pass, d_timeout;
    logic [64:0] d_cycles;
    logic [1:0]  d_exit_ch;
    logic [31:0] d_exitcode;

    replay_ctrl u0 (
        .clock(clock), .reset(reset), .tick_en(tick_en), .exit_vld(exit_vld), .exit_code(exit_code),
        .dut_reset(a_dut_reset), .running(a_running), .cycles(a_cycles), .done(a_done), .pass(a_pass),
        .timeout(a_timeout), .exit_ch(a_exit_ch), .exitcode(a_exitcode)
    );

    replay_ctrl #(.TIMEOUT(100)) u1 (
        .clock(clock), .reset(reset), .tick_en(tick_en), .exit_vld(exit_vld), .exit_code(exit_code),
        .dut_reset(b_dut_reset), .running(b_running), .cycles(b_cycles), .done(b_done), .pass(b_pass),
        .timeout(b_timeout), .exit_ch(b_exit_ch), .exitcode(b_exitcode)
    );

    replay_ctrl #(.CYC_W(4)) u2 (
        .clock(clock), .reset(reset), .tick_en(tick_en), .exit_vld(exit_vld), .exit_code(exit_code),
        .dut_reset(c_dut_reset), .running(c_running), .cycles(c_cycles), .done(c_done), .pass(c_pass),
        .timeout(c_timeout), .exit_ch(c_exit_ch), .exitcode(c_exitcode)
    );

    replay_ctrl #(.DRAIN_CYCLES(0)) u3 (
        .clock(clock), .reset(reset), .tick_en(tick_en), .exit_vld(exit_vld), .exit_code(exit_code),
        .dut_reset(d_dut_reset), .running(d_running), .cycles(d_cycles), .done(d_done), .pass(d_pass),
        .timeout(d_timeout), .exit_ch(d_exit_ch), .exitcode(d_exitcode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset for one edge, release, then walk the 5 HOLD cycles into RUN.
    task automatic restart();
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (5) step();
    endtask

    initial begin
        reset     = 1'b0;
        tick_en   = 1'b1;
        exit_vld  = 4'b0000;
        exit_code = '0;

        // ---- reset state and reset release timing ----
        step();
        check("rst_dut_reset", a_dut_reset, 1);
        check("rst_running",   a_running,   0);
        check("rst_cycles",    a_cycles,    0);
        check("rst_done",      a_done,      0);
        check("rst_pass",      a_pass,      0);
        check("rst_timeout",   a_timeout,   0);
        check("rst_exit_ch",   a_exit_ch,   0);
        check("rst_exitcode",  a_exitcode,  0);
        reset = 1'b1;
        repeat (4) step();
        check("hold_dut_reset_c4", a_dut_reset, 1);
        check("hold_running_c4",   a_running,   0);
        step();
        check("run_dut_reset_c5", a_dut_reset, 0);
        check("run_running_c5",   a_running,   1);
        check("run_cycles_c5",    a_cycles,    0);
        repeat (10) step();
        check("run_cycles_10", a_cycles, 10);
        check("run_done_10",   a_done,   0);

        // ---- single exit on channel 2 at cycles==20 ----
        repeat (10) step();
        check("run_cycles_20", a_cycles, 20);
        check("sat_cycles_w4", c_cycles, 15);
        exit_code = {32'h0000_0033, 32'h0000_0000, 32'h0000_0022, 32'h0000_0011};
        exit_vld  = 4'b0100;
        step();
        exit_vld  = 4'b0000;
        check("ex2_exit_ch",  a_exit_ch,  2);
        check("ex2_exitcode", a_exitcode, 0);
        check("ex2_cycles",   a_cycles,   21);
        check("ex2_running",  a_running,  0);
        check("ex2_done_n",   a_done,     0);
        check("ex2_sat_w4",   c_cycles,   15);
        check("nodrain_done_n", d_done,   0);
        step();
        check("nodrain_done_n1", d_done, 1);
        check("nodrain_pass_n1", d_pass, 1);
        check("ex2_done_n1",     a_done, 0);
        step();
        check("ex2_done_n2", a_done, 0);
        step();
        check("ex2_done_n3",   a_done,      1);
        check("ex2_pass_n3",   a_pass,      1);
        check("ex2_cycles_n3", a_cycles,    21);
        check("ex2_dutrst_n3", a_dut_reset, 0);

        // ---- two channels at once; later exit during drain ignored ----
        restart();
        repeat (3) step();
        check("ex13_cycles_pre", a_cycles, 3);
        exit_code = {32'h0000_0000, 32'h0000_0055, 32'h0000_0007, 32'h0000_0011};
        exit_vld  = 4'b1010;
        step();
        check("ex13_exit_ch",  a_exit_ch,  1);
        check("ex13_exitcode", a_exitcode, 32'h7);
        exit_vld  = 4'b0001;
        step();
        exit_vld  = 4'b0000;
        step();
        step();
        check("ex13_done",     a_done,     1);
        check("ex13_pass",     a_pass,     0);
        check("ex13_exit_ch2", a_exit_ch,  1);
        check("ex13_code2",    a_exitcode, 32'h7);
        check("ex13_cycles",   a_cycles,   4);

        // ---- watchdog with tick_en toggling ----
        restart();
        for (int i = 0; i < 99; i++) begin
            tick_en = 1'b1;
            step();
            tick_en = 1'b0;
            step();
        end
        check("wd_cycles_99",   b_cycles,  99);
        check("wd_timeout_pre", b_timeout, 0);
        step();
        check("wd_stall_timeout", b_timeout, 0);
        check("wd_stall_running", b_running, 1);
        tick_en = 1'b1;
        step();
        check("wd_timeout",   b_timeout,  1);
        check("wd_exitcode",  b_exitcode, 32'hFFFF_FFFF);
        check("wd_exit_ch",   b_exit_ch,  0);
        check("wd_cycles",    b_cycles,   100);
        check("wd_running",   b_running,  0);
        check("nowd_running", a_running,  1);
        check("nowd_cycles",  a_cycles,   100);
        repeat (3) step();
        check("wd_done", b_done, 1);
        check("wd_pass", b_pass, 0);

        // ---- exit and watchdog in the same cycle ----
        restart();
        repeat (99) step();
        check("wdx_cycles_99", b_cycles, 99);
        exit_code = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_1234};
        exit_vld  = 4'b0001;
        step();
        exit_vld  = 4'b0000;
        check("wdx_timeout",  b_timeout,  0);
        check("wdx_exit_ch",  b_exit_ch,  0);
        check("wdx_exitcode", b_exitcode, 32'h1234);
        check("wdx_cycles",   b_cycles,   100);
        repeat (3) step();
        check("wdx_done", b_done, 1);
        check("wdx_pass", b_pass, 0);

        // ---- reset during drain, then full rerun ----
        restart();
        repeat (4) step();
        exit_code = {32'h0000_0000, 32'h0000_0000, 32'h0000_0009, 32'h0000_0000};
        exit_vld  = 4'b0100;
        step();
        exit_vld  = 4'b0000;
        step();
        check("abort_pre_d_done", d_done, 1);
        reset = 1'b0;
        step();
        check("abort_done",      a_done,      0);
        check("abort_cycles",    a_cycles,    0);
        check("abort_dut_reset", a_dut_reset, 1);
        check("abort_exit_ch",   a_exit_ch,   0);
        check("abort_exitcode",  a_exitcode,  0);
        check("abort_d_done",    d_done,      0);
        reset = 1'b1;
        repeat (4) step();
        check("rerun_dut_reset_c4", a_dut_reset, 1);
        step();
        check("rerun_dut_reset_c5", a_dut_reset, 0);
        check("rerun_running",      a_running,   1);
        repeat (2) step();
        exit_code = {32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
        exit_vld  = 4'b0100;
        step();
        exit_vld  = 4'b0000;
        repeat (3) step();
        check("rerun_done",    a_done,    1);
        check("rerun_pass",    a_pass,    1);
        check("rerun_cycles",  a_cycles,  3);
        check("rerun_exit_ch", a_exit_ch, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
